// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one single-port memory between the instruction-fetch
// requester (i_*) and the data requester (d_*). One transaction is in flight at a
// time and each requester sees a REQ/ACK handshake.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration using a
// last-grant register; without it the data side has fixed priority over fetch.
module core_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              m_en_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  // Counter start value: the WAIT state lasts exactly MEM_LAT cycles.
  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic              win_d_q, win_d_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_d;

`ifdef MEM_ARB_RR_EN
  logic last_d_q, last_d_d;

  // Round-robin pick: on contention serve the side that was not granted last.
  always_comb begin
    grant_d = d_req_i & (~i_req_i | ~last_d_q);
  end
`else
  // Fixed priority pick: the data side wins whenever it is requesting.
  always_comb begin
    grant_d = d_req_i;
  end
`endif

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      win_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      win_d_q   <= win_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  // Next-state logic: grant in IDLE, strobe in ISSUE, count in WAIT, ack in ACK.
  always_comb begin
    state_d   = state_q;
    win_d_d   = win_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d_d  = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req_i || d_req_i) begin
          state_d = ISSUE;
          win_d_d = grant_d;
`ifdef MEM_ARB_RR_EN
          last_d_d = grant_d;
`endif
          if (grant_d) begin
            we_d    = d_we_i;
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
          end else begin
            we_d    = 1'b0;
            addr_d  = i_addr_i;
          end
        end
      end
      ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ACK;
          if (win_d_q) begin
            if (!we_q) begin
              d_rdata_d = m_rdata_i;
            end
          end else begin
            i_rdata_d = m_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state; address/data hold outside ISSUE.
  always_comb begin
    m_en_o    = (state_q == ISSUE);
    m_we_o    = (state_q == ISSUE) & we_q;
    m_addr_o  = addr_q;
    m_wdata_o = wdata_q;
    i_ack_o   = (state_q == ACK) & ~win_d_q;
    d_ack_o   = (state_q == ACK) & win_d_q;
    busy_o    = (state_q != IDLE);
    i_rdata_o = i_rdata_q;
    d_rdata_o = d_rdata_q;
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: drives fetch/data requests into core_mem_arbiter, models
// a fixed-latency memory behind it, and predicts grant order, timing and data
// from the arbitration rules using a shadow copy of memory.
module tb_core_mem_arbiter;

  localparam int LAT = 2;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        iReq;
  logic [31:0] iAddr;
  logic [31:0] iRdata;
  logic        iAck;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [31:0] dRdata;
  logic        dAck;
  logic        mEn;
  logic        mWe;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic [31:0] mRdata;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Environment memory: written words plus a fixed pattern for untouched ones.
  logic [31:0] mem [256];
  bit          written [256];
  logic [31:0] pipe [1:LAT];

  // Reference model state.
  logic [31:0] shadow [256];
  logic [31:0] modelIRdata = '0;
  logic [31:0] modelDRdata = '0;
  logic [31:0] modelWdata  = '0;
  bit          modelLastD  = 1'b0;

  core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .i_req_i   (iReq),
    .i_addr_i  (iAddr),
    .i_rdata_o (iRdata),
    .i_ack_o   (iAck),
    .d_req_i   (dReq),
    .d_we_i    (dWe),
    .d_addr_i  (dAddr),
    .d_wdata_i (dWdata),
    .d_rdata_o (dRdata),
    .d_ack_o   (dAck),
    .m_en_o    (mEn),
    .m_we_o    (mWe),
    .m_addr_o  (mAddr),
    .m_wdata_o (mWdata),
    .m_rdata_i (mRdata),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] initVal(input int a);
    logic [7:0] b;
    b = 8'(a);
    if (a == 32'h10) return 32'h0050_0093;
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  // Memory with LAT-cycle read pipeline; stage 1 carries junk when not reading.
  always @(posedge clk) begin
    if (mEn && mWe) begin
      mem[mAddr[7:0]]     <= mWdata;
      written[mAddr[7:0]] <= 1'b1;
    end
    if (mEn && !mWe)
      pipe[1] <= written[mAddr[7:0]] ? mem[mAddr[7:0]] : initVal(int'(mAddr[7:0]));
    else
      pipe[1] <= 32'hDEAD_0000 ^ 32'(cyc);
    for (int k = 2; k <= LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign mRdata = pipe[LAT];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One round: the chosen requesters raise REQ together; the model predicts
  // grant order, strobe/ack cycles and returned data.
  task automatic applyStimulus(input bit useI, input bit useD, input bit dropI,
                               input logic [31:0] ia, input logic [31:0] da,
                               input bit we, input logic [31:0] wd);
    int          n, nTxn, enSeen, iAcks, dAcks, limit, iAckCyc, dAckCyc;
    bit          firstD, isD;
    logic [31:0] expI, expD;
    int          expEnCyc [2];
    logic [31:0] expEnAddr [2];
    logic [31:0] expEnWe [2];
    logic [31:0] expEnWdata [2];
    iAckCyc = 0;
    dAckCyc = 0;
    @(posedge clk);
    #1;
    iReq   = useI;
    iAddr  = ia;
    dReq   = useD;
    dWe    = we;
    dAddr  = da;
    dWdata = wd;
    n      = cyc + 1;
    nTxn   = (useI && useD) ? 2 : 1;
    if (useI && useD) firstD = RR ? !modelLastD : 1'b1;
    else              firstD = useD;
    expI = modelIRdata;
    expD = modelDRdata;
    for (int g = 0; g < nTxn; g++) begin
      isD         = (g == 0) ? firstD : !firstD;
      expEnCyc[g] = n + g * (LAT + 3);
      modelLastD  = isD;
      if (isD) begin
        modelWdata    = wd;
        expEnAddr[g]  = da;
        expEnWe[g]    = 32'(we);
        expEnWdata[g] = modelWdata;
        dAckCyc       = expEnCyc[g] + LAT + 1;
        if (we) shadow[da[7:0]] = wd;
        else    expD = shadow[da[7:0]];
      end else begin
        expEnAddr[g]  = ia;
        expEnWe[g]    = 32'd0;
        expEnWdata[g] = modelWdata;
        iAckCyc       = expEnCyc[g] + LAT + 1;
        expI          = shadow[ia[7:0]];
      end
    end
    enSeen = 0;
    iAcks  = 0;
    dAcks  = 0;
    limit  = n + 2 * LAT + 8;
    while (cyc < limit) begin
      @(negedge clk);
      if (dropI && cyc == n) iReq = 1'b0;
      checkOutput("ack_exclusive", 32'(iAck & dAck), 32'd0);
      checkOutput("we_qualified", 32'(mWe & ~mEn), 32'd0);
      if (mEn) begin
        if (enSeen < 2) begin
          checkOutput("en_cycle", 32'(cyc), 32'(expEnCyc[enSeen]));
          checkOutput("m_addr", mAddr, expEnAddr[enSeen]);
          checkOutput("m_we", 32'(mWe), expEnWe[enSeen]);
          checkOutput("m_wdata", mWdata, expEnWdata[enSeen]);
          checkOutput("busy_active", 32'(busy), 32'd1);
        end
        enSeen++;
      end
      if (iAck) begin
        iAcks++;
        checkOutput("i_ack_cycle", 32'(cyc), 32'(iAckCyc));
        checkOutput("i_rdata", iRdata, expI);
        iReq = 1'b0;
      end
      if (dAck) begin
        dAcks++;
        checkOutput("d_ack_cycle", 32'(cyc), 32'(dAckCyc));
        checkOutput("d_rdata", dRdata, expD);
        dReq = 1'b0;
      end
    end
    iReq = 1'b0;
    dReq = 1'b0;
    checkOutput("en_count", 32'(enSeen), 32'(nTxn));
    checkOutput("i_ack_count", 32'(iAcks), 32'(useI));
    checkOutput("d_ack_count", 32'(dAcks), 32'(useD));
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("i_rdata_held", iRdata, expI);
    checkOutput("d_rdata_held", dRdata, expD);
    modelIRdata = expI;
    modelDRdata = expD;
  endtask

  initial begin
    int n;
    int stray;
    for (int a = 0; a < 256; a++) shadow[a] = initVal(a);
    rstN   = 1'b0;
    iReq   = 1'b0;
    iAddr  = '0;
    dReq   = 1'b0;
    dWe    = 1'b0;
    dAddr  = '0;
    dWdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_m_en", 32'(mEn), 32'd0);
    checkOutput("rst_acks", 32'({iAck, dAck}), 32'd0);
    checkOutput("rst_m_addr", mAddr, 32'd0);
    checkOutput("rst_i_rdata", iRdata, 32'd0);
    checkOutput("rst_d_rdata", dRdata, 32'd0);
    rstN = 1'b1;

    // Fetch only from 0x10.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    checkOutput("fetch_value", iRdata, 32'h0050_0093);

    // Store then load at 0x200.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 1'b1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 1'b0, 32'h1111_2222);
    checkOutput("load_value", dRdata, 32'hDEAD_BEEF);

    // Two contention rounds back to back.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 1'b0, 32'h0BAD_F00D);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h24, 32'h10, 1'b1, 32'hCAFE_0001);

    // Reset during WAIT: nothing acknowledged, everything back to zero.
    @(posedge clk);
    #1;
    iReq  = 1'b1;
    iAddr = 32'h33;
    n     = cyc + 1;
    while (cyc < n + 1) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    iReq = 1'b0;
    rstN = 1'b1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_m_addr", mAddr, 32'd0);
    checkOutput("abort_m_wdata", mWdata, 32'd0);
    checkOutput("abort_i_rdata", iRdata, 32'd0);
    checkOutput("abort_d_rdata", dRdata, 32'd0);
    modelIRdata = '0;
    modelDRdata = '0;
    modelWdata  = '0;
    modelLastD  = 1'b0;
    stray = 0;
    repeat (2 * LAT + 6) begin
      @(negedge clk);
      if (iAck || dAck || mEn) stray++;
    end
    checkOutput("abort_no_activity", 32'(stray), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h33, 32'h0, 1'b0, 32'h0);

    // Fetch request held for a single cycle still completes once.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 1'b0, 32'h0);

    // Random mix of single and contending requests over a small address range.
    for (int r = 0; r < 40; r++) begin
      int          sel;
      logic [31:0] ra, rb;
      sel = int'($urandom_range(1, 3));
      ra  = {24'($urandom), 8'($urandom_range(0, 31))};
      rb  = {24'($urandom), 8'($urandom_range(0, 31))};
      applyStimulus(sel[0], sel[1], 1'b0, ra, rb, 1'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
